// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result on the accept edge. MUL is an iterative
// shift-add that finishes WIDTH edges after accept. Results and flags are held
// while the consumer stalls. Carry/overflow change only on ADD/ADDI/SUB.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_OR   = 6'd5;
    localparam logic [5:0] OP_XOR  = 6'd6;
    localparam logic [5:0] OP_SLL  = 6'd7;
    localparam logic [5:0] OP_SRL  = 6'd8;
    localparam logic [5:0] OP_SRA  = 6'd9;
    localparam logic [5:0] OP_MUL  = 6'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Architectural state
    state_e             state_q,     state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               carry_q,     carry_d;
    logic               zero_q,      zero_d;
    logic               negative_q,  negative_d;
    logic               overflow_q,  overflow_d;
    logic               illegal_q,   illegal_d;

    // Multiplier datapath state
    logic [WIDTH-1:0]   mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [SHW-1:0]     cnt_q,       cnt_d;

    // Combinational helpers
    logic               accept_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   op_res_s;
    logic               op_carry_s;
    logic               op_ovf_s;
    logic               op_arith_s;
    logic               op_illegal_s;
    logic               op_is_mul_s;
    logic [WIDTH-1:0]   acc_step_s;

    // The stage can take a new op only when idle and the output slot is free or being drained.
    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    assign shamt_s    = b[SHW-1:0];
    assign sum_s      = {1'b0, a} + {1'b0, b};
    assign diff_s     = a - b;
    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    // Decode the offered opcode into a single-cycle result plus carry/overflow candidates.
    always_comb begin
        op_res_s     = {WIDTH{1'b0}};
        op_carry_s   = 1'b0;
        op_ovf_s     = 1'b0;
        op_arith_s   = 1'b0;
        op_illegal_s = 1'b0;
        op_is_mul_s  = 1'b0;
        case (opcode)
            OP_AND, OP_ANDI: begin
                op_res_s = a & b;
            end
            OP_ADD, OP_ADDI: begin
                op_res_s   = sum_s[WIDTH-1:0];
                op_carry_s = sum_s[WIDTH];
                op_ovf_s   = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
                op_arith_s = 1'b1;
            end
            OP_SUB: begin
                op_res_s   = diff_s;
                op_carry_s = (b > a);
                op_ovf_s   = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
                op_arith_s = 1'b1;
            end
            OP_OR: begin
                op_res_s = a | b;
            end
            OP_XOR: begin
                op_res_s = a ^ b;
            end
            OP_SLL: begin
                op_res_s = a << shamt_s;
            end
            OP_SRL: begin
                op_res_s = a >> shamt_s;
            end
            OP_SRA: begin
                op_res_s = $unsigned($signed(a) >>> shamt_s);
            end
            OP_MUL: begin
                op_is_mul_s = 1'b1;
            end
            default: begin
                op_illegal_s = 1'b1;
            end
        endcase
    end

    // Next-state logic for the IDLE/MUL controller, result register and flags.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op_is_mul_s) begin
                        state_d     = ST_MUL;
                        mcand_d     = a;
                        mplier_d    = b;
                        acc_d       = {WIDTH{1'b0}};
                        cnt_d       = SHW'(WIDTH - 1);
                        out_valid_d = 1'b0;
                    end else begin
                        result_d    = op_res_s;
                        zero_d      = (op_res_s == {WIDTH{1'b0}});
                        negative_d  = op_res_s[MSB];
                        illegal_d   = op_illegal_s;
                        out_valid_d = 1'b1;
                        if (op_arith_s) begin
                            carry_d    = op_carry_s;
                            overflow_d = op_ovf_s;
                        end else begin
                            carry_d    = carry_q;
                            overflow_d = overflow_q;
                        end
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_MUL: begin
                // One partial product per edge; the last edge publishes the sum directly.
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == {SHW{1'b0}}) begin
                    result_d    = acc_step_s;
                    zero_d      = (acc_step_s == {WIDTH{1'b0}});
                    negative_d  = acc_step_s[MSB];
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                    cnt_d       = cnt_q;
                end else begin
                    cnt_d       = cnt_q - SHW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset; a reset during MUL abandons the op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= {WIDTH{1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            cnt_q       <= {SHW{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32) with hand-computed expectations.
module tb_alu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry, zero, negative, overflow, illegal;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .carry(carry), .zero(zero), .negative(negative),
        .overflow(overflow), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        in_valid = 1'b1;
        opcode   = op;
        a        = av;
        b        = bv;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 6'd0; a = 32'd0; b = 32'd0;
        repeat (2) tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", result); end
        checks++; if ({carry, zero, negative, overflow, illegal} !== 5'b0) begin errors++;
            $display("FAIL reset_flags: got %b exp 00000", {carry, zero, negative, overflow, illegal}); end
        reset = 1'b0;
        // Mid-stream reset: produce a result, then reset asynchronously.
        drive(6'd1, 32'd5, 32'd7);
        tick;
        in_valid = 1'b0;
        checks++; if (result !== 32'd12 || out_valid !== 1'b1) begin errors++;
            $display("FAIL pre_reset_add: got %h/%b exp 0000000c/1", result, out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || result !== 32'd0) begin errors++;
            $display("FAIL async_reset: got %b/%h exp 0/00000000", out_valid, result); end
        #1 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_after_reset: got %b exp 1", in_ready); end
        tick;
    endtask

    task automatic test_add;
        drive(6'd1, 32'hFFFF_FFFF, 32'd1);
        tick;
        checks++; if (result !== 32'd0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL add_wrap_result: got %h/%b exp 00000000/1", result, out_valid); end
        checks++; if ({zero, carry, overflow, negative} !== 4'b1100) begin errors++;
            $display("FAIL add_wrap_flags: got zcvn=%b exp 1100", {zero, carry, overflow, negative}); end
        drive(6'd1, 32'h7FFF_FFFF, 32'd1);
        tick;
        in_valid = 1'b0;
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result: got %h exp 80000000", result); end
        checks++; if ({zero, carry, overflow, negative} !== 4'b0011) begin errors++;
            $display("FAIL add_ovf_flags: got zcvn=%b exp 0011", {zero, carry, overflow, negative}); end
    endtask

    task automatic test_sub_and;
        drive(6'd2, 32'd3, 32'd5);
        tick;
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h exp fffffffe", result); end
        checks++; if ({zero, carry, overflow, negative} !== 4'b0101) begin errors++;
            $display("FAIL sub_flags: got zcvn=%b exp 0101", {zero, carry, overflow, negative}); end
        drive(6'd0, 32'h0000_00F0, 32'h0000_000F);
        tick;
        in_valid = 1'b0;
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL and_result: got %h exp 00000000", result); end
        checks++; if ({zero, carry, overflow, negative} !== 4'b1100) begin errors++;
            $display("FAIL and_held_carry: got zcvn=%b exp 1100", {zero, carry, overflow, negative}); end
    endtask

    task automatic test_mul;
        logic [31:0] ma [3];
        logic [31:0] mb [3];
        logic [31:0] mexp [3];
        int cyc;
        int seen;
        ma[0] = 32'd1234;      mb[0] = 32'd5678;      mexp[0] = 32'd7006652;
        ma[1] = 32'hFFFF_FFFF; mb[1] = 32'hFFFF_FFFF; mexp[1] = 32'd1;
        ma[2] = 32'h0001_0000; mb[2] = 32'h0001_0000; mexp[2] = 32'd0;
        for (int t = 0; t < 3; t++) begin
            drive(6'd10, ma[t], mb[t]);
            tick;
            in_valid = 1'b0;
            a = 32'hDEAD_BEEF; b = 32'h1234_5678;   // inputs are don't-care after accept
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 40) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready t=%0d cyc=%0d: got %b exp 0", t, cyc, in_ready); end
                tick;
                cyc++;
            end
            checks++; if (cyc != 32) begin errors++; $display("FAIL mul_latency t=%0d: got %0d exp 32", t, cyc); end
            checks++; if (result !== mexp[t]) begin errors++; $display("FAIL mul_result t=%0d: got %h exp %h", t, result, mexp[t]); end
            checks++; if ({zero, negative, illegal, carry, overflow} !== {(mexp[t] == 32'd0), 4'b0010}) begin errors++;
                $display("FAIL mul_flags t=%0d: got znicv=%b exp %b", t, {zero, negative, illegal, carry, overflow}, {(mexp[t] == 32'd0), 4'b0010}); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_in_ready_done t=%0d: got %b exp 1", t, in_ready); end
        end
        // Reset during a MUL: no result must ever appear.
        drive(6'd10, 32'd1234, 32'd5678);
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL mul_abort_reset: got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            tick;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mul_abort_no_result: got %0d valid cycles exp 0", seen); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        drive(6'd9, 32'h8000_0000, 32'd4);
        tick;
        drive(6'd6, 32'hFF00_FF00, 32'h0FF0_0FF0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (result !== 32'hF800_0000 || out_valid !== 1'b1 || in_ready !== 1'b0 || negative !== 1'b1) begin errors++;
                $display("FAIL stall_hold i=%0d: got %h v=%b r=%b n=%b exp f8000000 1 0 1", i, result, out_valid, in_ready, negative); end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
        tick;
        checks++; if (result !== 32'hF0F0_F0F0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_first: got %h/%b exp f0f0f0f0/1", result, out_valid); end
        drive(6'd6, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        tick;
        in_valid = 1'b0;
        checks++; if (result !== 32'd0 || out_valid !== 1'b1 || zero !== 1'b1) begin errors++;
            $display("FAIL b2b_second: got %h/%b z=%b exp 00000000/1 z=1", result, out_valid, zero); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_ops;
        logic [5:0]  vop  [7];
        logic [31:0] va   [7];
        logic [31:0] vb   [7];
        logic [31:0] vexp [7];
        vop[0] = 6'd5; va[0] = 32'h0000_00A0; vb[0] = 32'h0000_0005; vexp[0] = 32'h0000_00A5;
        vop[1] = 6'd7; va[1] = 32'h0000_0001; vb[1] = 32'd31;        vexp[1] = 32'h8000_0000;
        vop[2] = 6'd8; va[2] = 32'h8000_0000; vb[2] = 32'd4;         vexp[2] = 32'h0800_0000;
        vop[3] = 6'd8; va[3] = 32'h8000_0000; vb[3] = 32'h0000_0024; vexp[3] = 32'h0800_0000;
        vop[4] = 6'd9; va[4] = 32'h4000_0000; vb[4] = 32'd1;         vexp[4] = 32'h2000_0000;
        vop[5] = 6'd3; va[5] = 32'h0000_00FF; vb[5] = 32'h0000_003C; vexp[5] = 32'h0000_003C;
        vop[6] = 6'd4; va[6] = 32'd10;        vb[6] = 32'hFFFF_FFFD; vexp[6] = 32'd7;
        for (int i = 0; i < 7; i++) begin
            drive(vop[i], va[i], vb[i]);
            tick;
            checks++; if (result !== vexp[i]) begin errors++; $display("FAIL op_vec i=%0d op=%0d: got %h exp %h", i, vop[i], result, vexp[i]); end
        end
        in_valid = 1'b0;
        checks++; if ({carry, overflow, negative} !== 3'b100) begin errors++;
            $display("FAIL addi_flags: got cvn=%b exp 100", {carry, overflow, negative}); end
    endtask

    task automatic test_illegal;
        drive(6'd1, 32'h8000_0000, 32'h8000_0000);
        tick;
        checks++; if ({result == 32'd0, carry, overflow, zero} !== 4'b1111) begin errors++;
            $display("FAIL add_neg_ovf: got %h c=%b v=%b z=%b exp 00000000 1 1 1", result, carry, overflow, zero); end
        drive(6'd63, 32'd5, 32'd6);
        tick;
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL illegal63_result: got %h exp 00000000", result); end
        checks++; if ({illegal, zero, negative, carry, overflow} !== 5'b11011) begin errors++;
            $display("FAIL illegal63_flags: got izncv=%b exp 11011", {illegal, zero, negative, carry, overflow}); end
        drive(6'd11, 32'hFFFF_FFFF, 32'd6);
        tick;
        checks++; if ({illegal, result == 32'd0} !== 2'b11) begin errors++;
            $display("FAIL illegal11: got i=%b result=%h exp 1 00000000", illegal, result); end
        drive(6'd2, 32'd5, 32'd5);
        tick;
        in_valid = 1'b0;
        checks++; if ({illegal, zero, carry, overflow, result == 32'd0} !== 5'b01001) begin errors++;
            $display("FAIL sub_equal: got izcv=%b result=%h exp 0100 00000000", {illegal, zero, carry, overflow}, result); end
        tick;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_and;
        test_mul;
        test_back_to_back;
        test_ops;
        test_illegal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational ALU in the execute stage. It accepts one operation per valid/ready handshake and returns a registered result with Z/N/C/V flags. Single-cycle ops complete in 1 cycle; a shift-add multiply takes WIDTH cycles. Results are held under downstream back-pressure. It sits between operand fetch/decode and writeback, and the flag outputs feed the branch unit.

## Interface
- WIDTH, default 32: operand/result width; must be ≥ 4 and a power of two.
- SHW, default $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: block can accept; combinational, `= (state==IDLE) && (!out_valid || out_ready)`.
- opcode, input, 6: operation select.
- a, input, WIDTH: source 1.
- b, input, WIDTH: source 2 or immediate (already extended by decode).
- out_valid, output, 1: result/flags valid.
- out_ready, input, 1: consumer accepts result.
- result, output, WIDTH: registered result.
- carry, zero, negative, overflow, output, 1 each: registered flags.
- illegal, output, 1: registered; set for an unsupported opcode.

## Operation
- Accept on a rising edge with in_valid && in_ready. The a, b and opcode values are captured on that edge; inputs are don't-care afterwards.
- Opcodes:
  - 0 AND: a&b.
  - 1 ADD: a+b.
  - 2 SUB: a−b.
  - 3 ANDI: a&b.
  - 4 ADDI: a+b.
  - 5 OR: a|b.
  - 6 XOR: a^b.
  - 7 SLL: a<<b[SHW-1:0].
  - 8 SRL: logical right shift.
  - 9 SRA: arithmetic right shift.
  - 10 MUL: low WIDTH bits of unsigned a*b, multi-cycle.
  - 11–63: result 0 and illegal=1.
- Arithmetic is modulo 2^WIDTH.
- ADD/ADDI flags:
  - carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - overflow = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
- SUB flags:
  - carry = borrow = (b > a), unsigned.
  - overflow = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
- All other ops leave carry and overflow unchanged; their previous values are held.
- zero = (result==0) and negative = result[MSB] update on every completed op, including illegal and MUL.
- illegal updates on every completed op.
- FSM IDLE→MUL:
  - IDLE: a single-cycle op is accepted; result and flags are written on the accept edge and out_valid←1.
  - On MUL accept: load multiplicand=a, multiplier=b, acc=0, cnt=WIDTH-1; go to MUL; out_valid←0.
  - MUL: on each edge, if multiplier[0] then acc+=multiplicand. Then multiplicand<<=1, multiplier>>=1, cnt−=1.
  - On the edge where cnt==0, write result=final acc, update zero/negative/illegal=0, out_valid←1, return to IDLE.
- out_valid clears on an edge with out_valid && out_ready && no new accept. When an accept occurs on the same edge, the new result replaces the old one and out_valid stays 1.
- While out_valid && !out_ready, result and all flags are held stable; in_ready=0.
- In state MUL, in_ready=0 regardless of out_ready.

## Timing
- Reset (async, immediate): state=IDLE; out_valid=0; result=0; carry=0; zero=0; negative=0; overflow=0; illegal=0; cnt=0; acc=0.
- Single-cycle latency:
  - Accept at edge k → out_valid=1 after edge k.
  - Throughput is 1 op/cycle when out_ready is held 1.
- MUL latency:
  - Accept at edge k → out_valid=1 after edge k+WIDTH.
  - in_ready=0 from after edge k until the cycle following the completion edge, provided out_ready is 1 in that cycle.
- Reset asserted mid-MUL aborts the operation; no result is produced and no flags are updated.
- Simultaneous out_ready and new accept on one edge: the old result is consumed and the new result is visible after that edge; no bubble.
- Flags always describe the op whose result is currently presented (except the held C/V on non-arith ops).

## Test plan
- Reset mid-stream → all outputs 0, in_ready=1 once reset deasserts.
- ADD a=0xFFFFFFFF, b=1 → result=0, zero=1, carry=1, overflow=0. Then ADD 0x7FFFFFFF+1 → result=0x80000000, negative=1, overflow=1, carry=0.
- SUB a=3, b=5 → result=0xFFFFFFFE, carry=1, negative=1, overflow=0. Then AND 0xF0&0x0F → result=0, zero=1, carry still 1.
- MUL a=1234, b=5678 with out_ready=1:
  - result=7006652 exactly 32 cycles after accept.
  - in_ready=0 throughout.
  - Assert reset at cycle 10 of a second MUL → no out_valid.
- Back-pressure: out_ready=0 for 4 cycles after SRA a=0x80000000, b=4 → result 0xF8000000 held stable, in_ready=0; then out_ready=1 with in_valid XOR op → back-to-back results with no gap.
- opcode=63 → result=0, illegal=1, zero=1, carry/overflow unchanged.
